// File: rtl/sram_pkg.sv
// Shared SRAM geometry, frame constants and the encoder state type.
// Used by frame_encoder (optional checksum macro: FRAME_ENCODER_CHECKSUM_EN).
package sram_pkg;

  localparam int SRAM_ADDR_COUNT = 20;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int MAP_H           = 640;
  localparam int MAP_V           = 480;
  localparam int FRAME_PIXELS    = MAP_H * MAP_V;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    RECOVER,
    DONE
  } EncState;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/frame_encoder.sv
// Streams one frame of pixel words into SRAM, one word per address from BASE_ADDR.
// Optional running XOR checksum output when FRAME_ENCODER_CHECKSUM_EN is defined.
module frame_encoder
  import sram_pkg::*;
#(
  parameter int ADDR_W    = sram_pkg::SRAM_ADDR_COUNT,
  parameter int DATA_W    = sram_pkg::SRAM_DATA_WIDTH,
  parameter int MAP_H     = sram_pkg::MAP_H,
  parameter int MAP_V     = sram_pkg::MAP_V,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_sram_writing,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_data,
  output logic [ADDR_W-1:0] o_pixel_counter,
  output logic              o_busy,
  output logic              o_done
`ifdef FRAME_ENCODER_CHECKSUM_EN
  ,output logic [DATA_W-1:0] o_checksum
`endif
);

  localparam int              FRAME_WORDS = frame_pixels(MAP_H, MAP_V);
  localparam logic [ADDR_W:0] LAST_COUNT  = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  // The whole frame must fit in the SRAM address space above BASE_ADDR.
  generate
    if (longint'(BASE_ADDR) + longint'(MAP_H) * longint'(MAP_V) > (longint'(1) << ADDR_W)) begin : g_bad_cfg
      $error("frame_encoder: frame does not fit in SRAM address space");
    end
  endgenerate

  EncState          state_reg;
  logic [ADDR_W:0]  count_inc;

  // One extra bit so a frame filling the whole address space still compares correctly.
  assign count_inc = {1'b0, o_pixel_counter} + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      o_ready         <= 1'b0;
      o_sram_writing  <= 1'b0;
      o_sram_addr     <= '0;
      o_sram_data     <= '0;
      o_pixel_counter <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
`ifdef FRAME_ENCODER_CHECKSUM_EN
      o_checksum      <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (i_start) begin
            state_reg       <= FETCH;
            o_ready         <= 1'b1;
            o_busy          <= 1'b1;
            o_done          <= 1'b0;
            o_pixel_counter <= '0;
            o_sram_addr     <= BASE;
`ifdef FRAME_ENCODER_CHECKSUM_EN
            o_checksum      <= '0;
`endif
          end
        end
        FETCH: begin
          if (i_valid) begin
            state_reg      <= WRITE;
            o_sram_data    <= i_data;
            o_ready        <= 1'b0;
            o_sram_writing <= 1'b1;
          end
        end
        WRITE: begin
          state_reg      <= RECOVER;
          o_sram_writing <= 1'b0;
        end
        RECOVER: begin
          // Address and data only move after WE has been high-to-low for a full cycle.
          o_pixel_counter <= count_inc[ADDR_W-1:0];
          o_sram_addr     <= o_sram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef FRAME_ENCODER_CHECKSUM_EN
          o_checksum      <= o_checksum ^ o_sram_data;
`endif
          if (count_inc == LAST_COUNT) begin
            state_reg <= DONE;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
          end else begin
            state_reg <= FETCH;
            o_ready   <= 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          o_ready        <= 1'b0;
          o_sram_writing <= 1'b0;
          o_busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_encoder.sv
// Directed-vector bench for frame_encoder on a 4x2 frame at base 0x100.
// Covers FRAME_ENCODER_CHECKSUM_EN when that macro is defined.
module tb_frame_encoder;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int NW = 8;
  localparam logic [AW-1:0] BASE = 20'h00100;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          o_sram_writing;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_data;
  logic [AW-1:0] o_pixel_counter;
  logic          o_busy;
  logic          o_done;
`ifdef FRAME_ENCODER_CHECKSUM_EN
  logic [DW-1:0] o_checksum;
`endif

  frame_encoder #(
    .ADDR_W(AW), .DATA_W(DW), .MAP_H(4), .MAP_V(2), .BASE_ADDR(32'h100)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_sram_writing(o_sram_writing),
    .o_sram_addr(o_sram_addr),
    .o_sram_data(o_sram_data),
    .o_pixel_counter(o_pixel_counter),
    .o_busy(o_busy),
    .o_done(o_done)
`ifdef FRAME_ENCODER_CHECKSUM_EN
    ,.o_checksum(o_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] src [NW];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            wr_cyc [$];
  int            pulse_err, own_err, hold_err;
  logic          prev_w = 1'b0;
  logic [AW-1:0] prev_a = '0;
  logic [DW-1:0] prev_d = '0;

  // Bus monitor: records every write and flags multi-cycle pulses or early address/data change.
  always @(negedge clk) begin
    if (o_sram_writing === 1'b1) begin
      wr_addr.push_back(o_sram_addr);
      wr_data.push_back(o_sram_data);
      wr_cyc.push_back(cyc);
      if (prev_w) pulse_err++;
      if (o_ready !== 1'b0) own_err++;
    end else if (prev_w && (o_sram_addr !== prev_a || o_sram_data !== prev_d)) begin
      hold_err++;
    end
    prev_w = (o_sram_writing === 1'b1);
    prev_a = o_sram_addr;
    prev_d = o_sram_data;
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    pulse_err = 0;
    own_err = 0;
    hold_err = 0;
    prev_w = 1'b0;
  endtask

  task automatic run_load(input int stall_at, input int stall_len, input int restart_at,
                          output int done_delta, output logic done_at_start);
    int start_cyc;
    int n;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    start_cyc = cyc;
    done_at_start = o_done;
    for (int k = 0; k < NW; k++) begin
      if (k == stall_at) begin
        i_valid = 1'b0;
        for (int i = 0; i < stall_len + 2; i++) begin
          @(posedge clk);
          #1;
          if (i >= 1) begin
            n_checks++;
            if (o_ready !== 1'b1 || o_sram_writing !== 1'b0) begin
              n_fail++;
              $display("FAIL stall_fetch: ready=%b writing=%b required ready=1 writing=0", o_ready, o_sram_writing);
            end
          end
        end
      end
      i_data = src[k];
      i_valid = 1'b1;
      if (k == restart_at) i_start = 1'b1;
      n = 0;
      @(negedge clk);
      while (o_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: word %0d not accepted within 50 cycles", k);
      end
      @(posedge clk);
      #1;
      i_start = 1'b0;
    end
    i_valid = 1'b0;
    n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    done_delta = cyc - start_cyc;
  endtask

  task automatic check_frame(input string tag);
    n_checks++;
    if (wr_addr.size() !== NW) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", tag, wr_addr.size(), NW);
    end else begin
      for (int k = 0; k < NW; k++) begin
        n_checks++;
        if (wr_addr[k] !== BASE + AW'(k) || wr_data[k] !== src[k]) begin
          n_fail++;
          $display("FAIL %s word%0d: got addr %h data %h required addr %h data %h",
                   tag, k, wr_addr[k], wr_data[k], BASE + AW'(k), src[k]);
        end
      end
    end
    n_checks++;
    if (o_pixel_counter !== AW'(NW) || o_busy !== 1'b0 || o_ready !== 1'b0 || o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_state: got cnt=%0d busy=%b ready=%b done=%b required cnt=8 busy=0 ready=0 done=1",
               tag, o_pixel_counter, o_busy, o_ready, o_done);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({o_ready, o_sram_writing, o_sram_addr, o_sram_data, o_pixel_counter, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h data=%h cnt=%0d flags=%b%b%b%b required all zero",
               o_sram_addr, o_sram_data, o_pixel_counter, o_ready, o_sram_writing, o_busy, o_done);
    end
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_state: got ready=%b busy=%b done=%b required 0 0 0", o_ready, o_busy, o_done);
    end
  endtask

  task automatic test_basic();
    int d;
    logic das;
    for (int k = 0; k < NW; k++) src[k] = 16'hA000 + 16'(k);
    clear_mon();
    run_load(-1, 0, -1, d, das);
    n_checks++;
    if (d !== 24) begin
      n_fail++;
      $display("FAIL basic_done_latency: got %0d cycles required 24", d);
    end
    check_frame("basic");
    for (int k = 1; k < wr_cyc.size(); k++) begin
      n_checks++;
      if (wr_cyc[k] - wr_cyc[k-1] !== 3) begin
        n_fail++;
        $display("FAIL basic_write_spacing%0d: got %0d cycles required 3", k, wr_cyc[k] - wr_cyc[k-1]);
      end
    end
    n_checks++;
    if (pulse_err !== 0 || own_err !== 0 || hold_err !== 0) begin
      n_fail++;
      $display("FAIL bus_ownership: got pulse=%0d own=%0d hold=%0d required 0 0 0", pulse_err, own_err, hold_err);
    end
  endtask

  task automatic test_backpressure();
    int d;
    logic das;
    clear_mon();
    run_load(2, 5, -1, d, das);
    n_checks++;
    if (d !== 29) begin
      n_fail++;
      $display("FAIL bp_done_latency: got %0d cycles required 29", d);
    end
    check_frame("backpressure");
  endtask

  task automatic test_async_reset();
    int n;
    int d;
    logic das;
    clear_mon();
    @(negedge clk);
    i_start = 1'b1;
    i_data = 16'h5555;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    n = 0;
    while (wr_addr.size() < 4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_ready, o_sram_writing, o_sram_addr, o_sram_data, o_pixel_counter, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got addr=%h data=%h cnt=%0d flags=%b%b%b%b required all zero",
               o_sram_addr, o_sram_data, o_pixel_counter, o_ready, o_sram_writing, o_busy, o_done);
    end
    @(negedge clk);
    i_rst = 1'b0;
    i_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (o_done !== 1'b0 || wr_addr.size() !== 4) begin
      n_fail++;
      $display("FAIL abandoned_frame: got done=%b writes=%0d required done=0 writes=4", o_done, wr_addr.size());
    end
    clear_mon();
    run_load(-1, 0, -1, d, das);
    check_frame("reload");
  endtask

  task automatic test_back_to_back();
    int d;
    logic das;
    for (int k = 0; k < NW; k++) src[k] = 16'h3C00 + 16'(k * 3);
    clear_mon();
    run_load(-1, 0, 1, d, das);
    n_checks++;
    if (d !== 24) begin
      n_fail++;
      $display("FAIL ignored_restart_latency: got %0d cycles required 24", d);
    end
    check_frame("ignored_restart");
    for (int k = 0; k < NW; k++) src[k] = 16'h0F00 - 16'(k);
    clear_mon();
    run_load(-1, 0, -1, d, das);
    n_checks++;
    if (das !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear_on_start: got done=%b required 0", das);
    end
    check_frame("second_load");
  endtask

`ifdef FRAME_ENCODER_CHECKSUM_EN
  task automatic test_checksum();
    int d;
    logic das;
    for (int k = 0; k < NW; k++) src[k] = 16'(1 << k);
    clear_mon();
    run_load(-1, 0, -1, d, das);
    n_checks++;
    if (o_checksum !== 16'h00FF) begin
      n_fail++;
      $display("FAIL checksum: got %h required 00ff", o_checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
`ifdef FRAME_ENCODER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_encoder.md
Name: frame_encoder

Overview:
- Upstream SRAM-write stage. Streams one full background frame of 16-bit pixel words from a source into external SRAM, one word per address, starting at BASE_ADDR.
- Drives the encode half of the top-level SRAM mux: sram_writing, addr_encode and data_encode.
- Publishes pixel_counter and frameEncode_done, which gate when FrameDecoder may read.
- Runs on the pixel clock, alongside FrameDecoder.

Parameters:
- ADDR_W, 20, SRAM address width (matches sram_pkg::SRAM_ADDR_COUNT).
- DATA_W, 16, SRAM word width (matches sram_pkg::SRAM_DATA_WIDTH).
- MAP_H, 640, frame width in pixels.
- MAP_V, 480, frame height in pixels.
- BASE_ADDR, 0, SRAM address of pixel (0,0).

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous reset, active-high
- i_start  in  1  one-cycle pulse; begins a frame load
- i_data  in  DATA_W  source pixel word
- i_valid  in  1  i_data valid
- o_ready  out  1  encoder accepts i_data this cycle
- o_sram_writing  out  1  encoder owns SRAM bus; drives WE_N low
- o_sram_addr  out  ADDR_W  write address
- o_sram_data  out  DATA_W  write data
- o_pixel_counter  out  ADDR_W  words committed to SRAM in this load
- o_busy  out  1  load in progress
- o_done  out  1  full frame written; held until next i_start

Behaviour:
- Reset (async, i_rst=1). All outputs 0, state IDLE, counters 0. Reset mid-load abandons the frame. No partial o_done.
- States: IDLE, FETCH, WRITE, RECOVER, DONE.
- IDLE:
  - o_ready=0.
  - i_start -> FETCH; pixel_counter:=0; address:=BASE_ADDR; o_busy=1.
- FETCH:
  - o_ready=1.
  - On i_valid&&o_ready, latch i_data into data register -> WRITE.
  - Without i_valid, stay in FETCH with no timeout.
- WRITE (exactly 1 cycle):
  - o_sram_writing=1; o_sram_addr and o_sram_data stable from latched values; o_ready=0.
  - Next state RECOVER.
- RECOVER (1 cycle):
  - o_sram_writing=0; address and data held, so WE deasserts with data/address unchanged.
  - pixel_counter+=1, address+=1.
  - If new pixel_counter == MAP_H*MAP_V -> DONE, else -> FETCH.
- Throughput: 3 cycles per word minimum (FETCH, WRITE, RECOVER). Accept-to-writing latency is 1 cycle.
- DONE:
  - o_done=1, o_busy=0, o_ready=0.
  - i_start -> FETCH, clears o_done and pixel_counter, restarting the load.
- i_start in FETCH/WRITE/RECOVER is ignored (no restart mid-frame).
- Source side: i_valid while o_ready=0 is not consumed; the source holds data.
- Width rules:
  - Address = BASE_ADDR + pixel_counter, truncated to ADDR_W.
  - Elaboration assertion: BASE_ADDR + MAP_H*MAP_V <= 2**ADDR_W.
  - pixel_counter never exceeds MAP_H*MAP_V and never wraps.
- o_sram_writing is never 1 outside WRITE. This guarantees FrameDecoder reads are never corrupted except during that cycle.

Optional Feature:
- Macro FRAME_ENCODER_CHECKSUM_EN.
- When defined:
  - Adds output o_checksum (DATA_W bits): running XOR of every word written this load.
  - Updated in RECOVER; cleared on i_start and on reset.
  - Valid when o_done=1.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- sram_pkg holds ADDR_W/DATA_W sources (SRAM_ADDR_COUNT, SRAM_DATA_WIDTH), MAP_H/MAP_V constants and the FRAME_PIXELS = MAP_H*MAP_V localparam.
- The encoder state enum (EncState: IDLE, FETCH, WRITE, RECOVER, DONE) also goes in sram_pkg.
- No sub-module needed. The optional checksum is an inline register. A single FSM plus datapath is natural.

Test Plan:
- Basic load, MAP_H=4, MAP_V=2, BASE_ADDR=0x100, i_valid always 1, data 0xA000..0xA007, pulse i_start -> 8 writes to 0x100..0x107 with matching data; each o_sram_writing pulse is 1 cycle with gaps of 2; o_done=1 after 24 cycles; pixel_counter=8.
- Back-pressure: same frame, i_valid low 5 cycles before word 3 -> encoder waits in FETCH with o_ready=1 and no write; final SRAM contents identical; o_done delayed by 5 cycles.
- Async reset mid-frame: assert i_rst after 4th write (no clock edge needed) -> all outputs 0 immediately; o_done never rises; a new i_start reloads from 0x100.
- Ignored restart: i_start pulsed during word 2 -> no effect; exactly 8 writes occur; then i_start in DONE -> o_done clears within 1 cycle and a second load of 8 words follows.
- Bus ownership: monitor over a full load -> o_sram_writing=1 only in WRITE; address and data are unchanged on the cycle after o_sram_writing falls.
- Checksum (FRAME_ENCODER_CHECKSUM_EN): data 0x0001,0x0002,0x0004,0x0008,0x0010,0x0020,0x0040,0x0080 -> o_checksum=0x00FF at o_done.
